// File: rtl/pfe_req_sched_pkg.sv
// Shared types and constants for the prefetch request scheduler.
// Widths track SC_laddr_type / SC_sptbr_type / PF_delta_type / PF_weigth_type.
package pfe_sched_pkg;
  localparam int LADDR_W    = 39;
  localparam int SPTBR_W    = 38;
  localparam int DELTA_W    = 8;
  localparam int WEIGHT_W   = 4;
  localparam int PAGE_OFS_W = 6;
  localparam int WTH_L2_DEF = 4;
  localparam int WTH_DC_DEF = 10;
  localparam int NUM_PIPES  = 2;

  typedef struct packed {
    logic [LADDR_W-1:0] laddr;
    logic [SPTBR_W-1:0] sptbr;
    logic               l2;
  } PF_SCHED_ENTRY;

  // Line address plus sign-extended delta; wraps modulo 2^LADDR_W.
  function automatic logic [LADDR_W-1:0] cand_addr(input logic [LADDR_W-1:0] base,
                                                   input logic [DELTA_W-1:0] d);
    return base + {{(LADDR_W-DELTA_W){d[DELTA_W-1]}}, d};
  endfunction

  function automatic logic [1:0] cnt2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/pfe_req_sched_if.sv
// Op stream in, two prefetch request pipes out; valid/retry handshake on each.
interface pfe_req_sched_if;
  import pfe_sched_pkg::*;
  logic                op_valid;
  logic                op_retry;
  logic [DELTA_W-1:0]  op_d;
  logic [WEIGHT_W-1:0] op_w;
  logic [DELTA_W-1:0]  op_d2;
  logic [WEIGHT_W-1:0] op_w2;
  logic [LADDR_W-1:0]  op_laddr;
  logic [SPTBR_W-1:0]  op_sptbr;
  logic                req0_valid, req0_retry, req0_l2;
  logic [LADDR_W-1:0]  req0_laddr;
  logic [SPTBR_W-1:0]  req0_sptbr;
  logic                req1_valid, req1_retry, req1_l2;
  logic [LADDR_W-1:0]  req1_laddr;
  logic [SPTBR_W-1:0]  req1_sptbr;

  modport master (
    output op_valid, op_d, op_w, op_d2, op_w2, op_laddr, op_sptbr,
    input  op_retry,
    input  req0_valid, req0_laddr, req0_sptbr, req0_l2,
    input  req1_valid, req1_laddr, req1_sptbr, req1_l2,
    output req0_retry, req1_retry
  );
  modport slave (
    input  op_valid, op_d, op_w, op_d2, op_w2, op_laddr, op_sptbr,
    output op_retry,
    output req0_valid, req0_laddr, req0_sptbr, req0_l2,
    output req1_valid, req1_laddr, req1_sptbr, req1_l2,
    input  req0_retry, req1_retry
  );
endinterface

// File: rtl/pfe_req_sched_fifo.sv
// Per-pipe request FIFO: up to two pushes and one pop per cycle, registered head.
// free_nxt_o reports free slots after this cycle's update.
module pfe_sched_fifo
  import pfe_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               push_n_i,
  input  PF_SCHED_ENTRY [1:0]      push_d_i,
  input  logic                     pop_i,
  output logic                     vld_o,
  output PF_SCHED_ENTRY            head_o,
  output logic [AW:0]              free_nxt_o
);
  PF_SCHED_ENTRY [DEPTH-1:0] mem_q, mem_d;
  PF_SCHED_ENTRY             head_q, head_d;
  logic [AW-1:0]             rd_q, rd_d, wr_q, wr_d, wr1;
  logic [AW:0]               cnt_q, cnt_d;
  logic                      pop;

  assign vld_o  = (cnt_q != '0);
  assign head_o = head_q;
  assign pop    = pop_i & vld_o;
  assign wr1    = wr_q + AW'(1);

  always_comb begin
    mem_d = mem_q;
    if (push_n_i != 2'd0) mem_d[wr_q] = push_d_i[0];
    if (push_n_i == 2'd2) mem_d[wr1]  = push_d_i[1];
    wr_d  = wr_q + AW'(push_n_i);
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push_n_i) - (AW+1)'(pop);
    // Head follows the post-update read pointer so a push into an empty FIFO shows next cycle.
    head_d     = mem_d[rd_d];
    free_nxt_o = (AW+1)'(DEPTH) - cnt_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q  <= '0;
      head_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/pfe_req_sched.sv
// Prefetch request scheduler: expands ops into two candidates, filters, steers by bank bit.
// Build option PFE_SCHED_PAGECHK_EN drops candidates that leave the trigger's 4KB page.
module pfe_req_sched
  import pfe_sched_pkg::*;
#(
  parameter int WTH_L2 = WTH_L2_DEF,
  parameter int WTH_DC = WTH_DC_DEF,
  parameter int DEPTH  = 4,
  parameter int STAT_W = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  pfe_req_sched_if.slave    bus,
  output logic [STAT_W-1:0] stat_nissued,
  output logic [STAT_W-1:0] stat_ndrop
);
  logic                op_retry_q, op_retry_d;
  logic [STAT_W-1:0]   iss_q, iss_d, drop_q, drop_d;
  logic                acc, v1, v2, v2e, dup, l2_1, l2_2, pg1, pg2;
  logic [LADDR_W-1:0]  addr1, addr2;
  PF_SCHED_ENTRY       e1, e2;
  logic [1:0]          iss_inc, drop_inc;
  logic [STAT_W:0]     iss_sum, drop_sum;

  logic [NUM_PIPES-1:0][1:0]    push_n;
  PF_SCHED_ENTRY [NUM_PIPES-1:0][1:0] push_d;
  logic [NUM_PIPES-1:0]         pipe_vld, pipe_retry, pop;
  PF_SCHED_ENTRY [NUM_PIPES-1:0] head;
  logic [NUM_PIPES-1:0][AW:0]   free_nxt;

  assign acc = bus.op_valid & ~op_retry_q;

  always_comb begin
    addr1 = cand_addr(bus.op_laddr, bus.op_d);
    addr2 = cand_addr(bus.op_laddr, bus.op_d2);
`ifdef PFE_SCHED_PAGECHK_EN
    pg1 = (addr1[LADDR_W-1:PAGE_OFS_W] == bus.op_laddr[LADDR_W-1:PAGE_OFS_W]);
    pg2 = (addr2[LADDR_W-1:PAGE_OFS_W] == bus.op_laddr[LADDR_W-1:PAGE_OFS_W]);
`else
    pg1 = 1'b1;
    pg2 = 1'b1;
`endif
    v1   = (bus.op_d  != '0) && (int'(bus.op_w)  >= WTH_L2) && pg1;
    v2   = (bus.op_d2 != '0) && (int'(bus.op_w2) >= WTH_L2) && pg2;
    l2_1 = (int'(bus.op_w)  < WTH_DC);
    l2_2 = (int'(bus.op_w2) < WTH_DC);
    // Identical targets merge into one entry; DC fill wins if either asks for it.
    dup  = v1 & v2 & (addr1 == addr2);
    v2e  = v2 & ~dup;
    e1   = '{laddr: addr1, sptbr: bus.op_sptbr, l2: dup ? (l2_1 & l2_2) : l2_1};
    e2   = '{laddr: addr2, sptbr: bus.op_sptbr, l2: l2_2};
  end

  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
    logic c1, c2;
    assign c1           = acc & v1  & (addr1[0] == 1'(p));
    assign c2           = acc & v2e & (addr2[0] == 1'(p));
    assign push_n[p]    = cnt2(c1, c2);
    assign push_d[p][0] = c1 ? e1 : e2;
    assign push_d[p][1] = e2;
    assign pop[p]       = pipe_vld[p] & ~pipe_retry[p];

    pfe_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_n_i  (push_n[p]),
      .push_d_i  (push_d[p]),
      .pop_i     (pop[p]),
      .vld_o     (pipe_vld[p]),
      .head_o    (head[p]),
      .free_nxt_o(free_nxt[p])
    );
  end

  assign pipe_retry     = {bus.req1_retry, bus.req0_retry};
  assign bus.req0_valid = pipe_vld[0];
  assign bus.req0_laddr = head[0].laddr;
  assign bus.req0_sptbr = head[0].sptbr;
  assign bus.req0_l2    = head[0].l2;
  assign bus.req1_valid = pipe_vld[1];
  assign bus.req1_laddr = head[1].laddr;
  assign bus.req1_sptbr = head[1].sptbr;
  assign bus.req1_l2    = head[1].l2;
  assign bus.op_retry   = op_retry_q;
  assign stat_nissued   = iss_q;
  assign stat_ndrop     = drop_q;

  always_comb begin
    // Two free slots per pipe guarantee the next accepted op fits wherever it steers.
    op_retry_d = (free_nxt[0] < (AW+1)'(2)) | (free_nxt[1] < (AW+1)'(2));
    iss_inc    = cnt2(pop[0], pop[1]);
    drop_inc   = acc ? (2'd2 - cnt2(v1, v2e)) : 2'd0;
    iss_sum    = {1'b0, iss_q}  + (STAT_W+1)'(iss_inc);
    drop_sum   = {1'b0, drop_q} + (STAT_W+1)'(drop_inc);
    iss_d      = iss_sum[STAT_W]  ? '1 : iss_sum[STAT_W-1:0];
    drop_d     = drop_sum[STAT_W] ? '1 : drop_sum[STAT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_retry_q <= 1'b0;
      iss_q      <= '0;
      drop_q     <= '0;
    end else begin
      op_retry_q <= op_retry_d;
      iss_q      <= iss_d;
      drop_q     <= drop_d;
    end
  end
endmodule

// File: tb/tb_pfe_req_sched.sv
// Scoreboarded random/directed bench for pfe_req_sched against a rule-level model.
module tb_pfe_req_sched;
  import pfe_sched_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pfe_req_sched_if bus();
  logic [15:0] stat_nissued, stat_ndrop;

  pfe_req_sched #(.DEPTH(4), .STAT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .stat_nissued(stat_nissued), .stat_ndrop(stat_ndrop)
  );

  int n_chk = 0, n_pass = 0;
  int exp_iss = 0, exp_drop = 0;
  bit in_reset = 1'b1;
  int rr_mode = 0;
  PF_SCHED_ENTRY q0[$], q1[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: spec rules evaluated with plain integer arithmetic.
  task automatic model_op(input logic [38:0] la, input logic [37:0] sp,
                          input logic [7:0] d1, input logic [3:0] w1,
                          input logic [7:0] d2, input logic [3:0] w2);
    longint mask = (longint'(1) <<< 39) - 1;
    longint base = longint'(la);
    longint a[2];
    int     dd[2], ww[2];
    bit     ok[2], l2[2];
    PF_SCHED_ENTRY e;
    dd[0] = int'($signed(d1)); dd[1] = int'($signed(d2));
    ww[0] = int'(w1);          ww[1] = int'(w2);
    for (int k = 0; k < 2; k++) begin
      a[k]  = (base + longint'(dd[k])) & mask;
      ok[k] = (dd[k] != 0) && (ww[k] >= 4);
`ifdef PFE_SCHED_PAGECHK_EN
      if ((a[k] >> 6) != (base >> 6)) ok[k] = 1'b0;
`endif
      l2[k] = (ww[k] < 10);
    end
    if (ok[0] && ok[1] && a[0] == a[1]) begin
      l2[0] = l2[0] && l2[1];
      ok[1] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      if (ok[k]) begin
        e.laddr = 39'(a[k]); e.sptbr = sp; e.l2 = l2[k];
        if (a[k] % 2 == 1) q1.push_back(e); else q0.push_back(e);
      end else exp_drop++;
    end
  endtask

  // Retry driver for both request pipes.
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      1: begin bus.req0_retry = ($urandom % 4 == 0); bus.req1_retry = ($urandom % 4 == 0); end
      2: begin bus.req0_retry = 1'b1; bus.req1_retry = 1'b0; end
      3: begin bus.req0_retry = 1'b1; bus.req1_retry = 1'b1; end
      default: begin bus.req0_retry = 1'b0; bus.req1_retry = 1'b0; end
    endcase
  end

  // Monitor: every transfer seen on a pipe is popped against its expected queue.
  always @(negedge clk) begin
    PF_SCHED_ENTRY e;
    if (!in_reset) begin
      if (bus.req0_valid && !bus.req0_retry) begin
        exp_iss++;
        if (q0.size() == 0) chk("req0_unexpected", 1, 0);
        else begin
          e = q0.pop_front();
          chk("req0_laddr", bus.req0_laddr, e.laddr);
          chk("req0_sptbr", bus.req0_sptbr, e.sptbr);
          chk("req0_l2", bus.req0_l2, e.l2);
        end
      end
      if (bus.req1_valid && !bus.req1_retry) begin
        exp_iss++;
        if (q1.size() == 0) chk("req1_unexpected", 1, 0);
        else begin
          e = q1.pop_front();
          chk("req1_laddr", bus.req1_laddr, e.laddr);
          chk("req1_sptbr", bus.req1_sptbr, e.sptbr);
          chk("req1_l2", bus.req1_l2, e.l2);
        end
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (!in_reset) begin
      chk("stat_nissued", stat_nissued, exp_iss);
      chk("stat_ndrop", stat_ndrop, exp_drop);
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
  endtask

  // Offers one op until taken; model is updated on the cycle the DUT will accept it.
  task automatic send_op(input logic [38:0] la, input logic [7:0] d1, input logic [3:0] w1,
                         input logic [7:0] d2, input logic [3:0] w2, input int max_wait);
    logic [37:0] sp;
    sp = 38'({$urandom, $urandom});
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.op_laddr = la; bus.op_sptbr = sp;
    bus.op_d = d1; bus.op_w = w1; bus.op_d2 = d2; bus.op_w2 = w2;
    for (int i = 0; i <= max_wait; i++) begin
      @(negedge clk);
      if (!bus.op_retry) begin
        model_op(la, sp, d1, w1, d2, w2);
        return;
      end
    end
    chk("op_accept_timeout", 0, 1);
  endtask

  task automatic drain(input int bound);
    rr_mode = 0;
    for (int i = 0; i < bound && (q0.size() + q1.size()) != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    chk("drain_left", q0.size() + q1.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [38:0] la;
    logic [7:0]  d1, d2;
    bus.op_valid = 1'b0; bus.op_laddr = '0; bus.op_sptbr = '0;
    bus.op_d = '0; bus.op_w = '0; bus.op_d2 = '0; bus.op_w2 = '0;
    #1;
    chk("rst_req0_valid", bus.req0_valid, 0);
    chk("rst_req1_valid", bus.req1_valid, 0);
    chk("rst_op_retry", bus.op_retry, 0);
    chk("rst_req0_laddr", bus.req0_laddr, 0);
    chk("rst_nissued", stat_nissued, 0);
    chk("rst_ndrop", stat_ndrop, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1; in_reset = 1'b0;

    // Single op: both candidates visible one cycle after acceptance.
    send_op(39'h100, 8'd1, 4'd12, 8'd2, 4'd6, 10);
    idle();
    chk("lat_req0_valid", bus.req0_valid, 1);
    chk("lat_req1_valid", bus.req1_valid, 1);
    drain(50);
    chk("t1_nissued", stat_nissued, 2);

    send_op(39'h100, 8'd0, 4'd15, 8'd3, 4'd2, 10);
    idle();
    drain(50);
    chk("drop_ndrop", stat_ndrop, 2);

    send_op(39'h100, 8'd4, 4'd5, 8'd4, 4'd11, 10);
    idle();
    drain(50);
    chk("dup_ndrop", stat_ndrop, 3);
    chk("dup_nissued", stat_nissued, 3);

    send_op(39'h13F, 8'd1, 4'd12, 8'd0, 4'd0, 10);
    send_op('1, 8'd1, 4'd12, 8'hFF, 4'd12, 10);
    idle();
    drain(50);

    // Backpressure on pipe 0: two even-target ops fill FIFO0 and raise op_retry.
    rr_mode = 2;
    repeat (2) @(posedge clk);
    send_op(39'h200, 8'd2, 4'd12, 8'd4, 4'd12, 10);
    send_op(39'h210, 8'd2, 4'd12, 8'd4, 4'd12, 10);
    idle();
    chk("bp_op_retry", bus.op_retry, 1);
    fork
      send_op(39'h220, 8'd2, 4'd12, 8'd4, 4'd12, 30);
      begin repeat (6) @(posedge clk); rr_mode = 0; end
    join
    idle();
    drain(100);

    rr_mode = 1;
    for (int n = 0; n < 400; n++) begin
      la = 39'({$urandom, $urandom});
      if ($urandom % 3 == 0) la[5:0] = ($urandom % 2) ? 6'h3F : 6'h00;
      d1 = 8'($urandom_range(0, 16) - 8);
      d2 = ($urandom % 5 == 0) ? d1 : 8'($urandom_range(0, 16) - 8);
      if ($urandom % 16 == 0) d2 = 8'($urandom);
      send_op(la, d1, 4'($urandom), d2, 4'($urandom), 60);
      if ($urandom % 4 == 0) idle();
    end
    idle();
    drain(500);

    // Async reset with both pipes stalled and occupied.
    rr_mode = 3;
    repeat (2) @(posedge clk);
    for (int n = 0; n < 3; n++) send_op(39'h300 + 39'(n * 16), 8'd1, 4'd12, 8'd2, 4'd12, 10);
    idle();
    @(posedge clk); #3;
    in_reset = 1'b1; reset = 1'b0;
    #1;
    chk("arst_req0_valid", bus.req0_valid, 0);
    chk("arst_req1_valid", bus.req1_valid, 0);
    chk("arst_op_retry", bus.op_retry, 0);
    chk("arst_nissued", stat_nissued, 0);
    chk("arst_ndrop", stat_ndrop, 0);
    q0.delete(); q1.delete();
    exp_iss = 0; exp_drop = 0;
    rr_mode = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1; in_reset = 1'b0;
    send_op(39'h100, 8'd1, 4'd12, 8'd2, 4'd6, 10);
    idle();
    chk("post_rst_req1_valid", bus.req1_valid, 1);
    drain(50);
    chk("post_rst_nissued", stat_nissued, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
